ram_port_initiator: RTL and testbench

- Request-side bridge that drives one port of the team's dual-port data RAM (en / byte-wen / addr / wdata inputs, rdata output one clock after en).
- Accepts in-order read/write requests on a valid/ready bus and issues them to the RAM port.
- Captures read data on the cycle after issue and returns exactly one in-order response per request through a registered response FIFO with backpressure.
- Sits between a core/LSU-style master and a RAM port.

---
 rtl/ram_port_initiator_if.sv | 32 +++
 rtl/ram_port_initiator.sv | 108 ++++++++++
 tb/tb_ram_port_initiator.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_initiator_if
// Purpose  : Request/response valid-ready bus between a master and the
//            RAM port initiator.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_port_initiator_if #(
    parameter int NADDRBIT  = 6,
    parameter int NDATABYTE = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [NDATABYTE-1:0]   req_wen;
    logic [NADDRBIT-1:0]    req_addr;
    logic [NDATABYTE*8-1:0] req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_write;
    logic [NDATABYTE*8-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_initiator.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_initiator
// Purpose  : Issues in-order read/write requests to one RAM port and returns
//            one in-order response per request through a response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_initiator #(
    parameter int  NDATA     = 64,
    parameter int  NDATABYTE = 4,
    parameter int  NRSPBUF   = 3,
    localparam int NADDRBIT  = $clog2(NDATA)
) (
    input  logic                   clock,
    input  logic                   reset,
    ram_port_initiator_if.slave    bus,
    output logic                   o_ram_en,
    output logic [NDATABYTE-1:0]   o_ram_wen,
    output logic [NADDRBIT-1:0]    o_ram_addr,
    output logic [NDATABYTE*8-1:0] o_ram_wdata,
    input  logic [NDATABYTE*8-1:0] i_ram_rdata
);
    localparam int c_DW   = NDATABYTE * 8;
    localparam int c_PTRW = (NRSPBUF > 1) ? $clog2(NRSPBUF) : 1;
    localparam int c_CNTW = $clog2(NRSPBUF + 1);

    logic                w_fire;
    logic                w_push;
    logic                w_pop;
    logic                w_req_ready;
    logic                w_rsp_valid;

    logic [c_CNTW-1:0]   r_count;
    logic                r_inflight;
    logic                r_inflight_wr;
    logic [c_PTRW-1:0]   r_wptr;
    logic [c_PTRW-1:0]   r_rptr;
    logic [NADDRBIT-1:0] r_addr_hold;
    logic [c_DW-1:0]     r_wdata_hold;
    logic                r_buf_write [NRSPBUF];
    logic [c_DW-1:0]     r_buf_data  [NRSPBUF];

    function automatic logic [c_PTRW-1:0] f_ptr_inc(input logic [c_PTRW-1:0] p);
        return (p == c_PTRW'(NRSPBUF - 1)) ? '0 : p + c_PTRW'(1);
    endfunction

    // Inflight requests reserve a FIFO slot so the capture never overflows.
    assign w_req_ready = reset && ((int'(r_count) + int'(r_inflight)) < NRSPBUF);
    assign w_fire      = bus.req_valid && w_req_ready;
    assign w_push      = r_inflight;
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid && bus.rsp_ready;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_write = w_rsp_valid && r_buf_write[r_rptr];
    assign bus.rsp_rdata = w_rsp_valid ? r_buf_data[r_rptr] : '0;

    assign o_ram_en    = w_fire;
    assign o_ram_wen   = w_fire ? bus.req_wen   : '0;
    assign o_ram_addr  = w_fire ? bus.req_addr  : r_addr_hold;
    assign o_ram_wdata = w_fire ? bus.req_wdata : r_wdata_hold;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_inflight_wr <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_addr_hold   <= '0;
            r_wdata_hold  <= '0;
        end else begin
            r_inflight    <= w_fire;
            r_inflight_wr <= w_fire && (|bus.req_wen);
            if (w_fire) begin
                r_addr_hold  <= bus.req_addr;
                r_wdata_hold <= bus.req_wdata;
            end
            if (w_push) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNTW'(1);
                2'b01:   r_count <= r_count - c_CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf_write[r_wptr] <= r_inflight_wr;
            r_buf_data[r_wptr]  <= r_inflight_wr ? '0 : i_ram_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(w_push && !w_pop && (r_count == c_CNTW'(NRSPBUF))));
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ram_port_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_initiator
// Purpose  : Self-checking bench for ram_port_initiator with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_initiator;
    localparam int NDATA = 64, NDATABYTE = 4, NRSPBUF = 3, NADDRBIT = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] ram_mem [NDATA];
    logic [31:0] ref_mem [NDATA];

    always #5 clock = ~clock;

    ram_port_initiator_if #(.NADDRBIT(NADDRBIT), .NDATABYTE(NDATABYTE)) bus ();

    ram_port_initiator #(.NDATA(NDATA), .NDATABYTE(NDATABYTE), .NRSPBUF(NRSPBUF)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .o_ram_en(ram_en), .o_ram_wen(ram_wen), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    always @(posedge clock) begin
        if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) ram_mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'h0, act}, {31'h0, exp});
    endtask

    // Scoreboard: expected responses are built from a reference memory at fire time.
    typedef struct packed { logic write; logic [31:0] data; } rsp_t;
    rsp_t        exp_q[$];
    rsp_t        exp_e;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data    = 32'h0;

    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check1("head_valid_hold", bus.rsp_valid, 1'b1);
                check32("head_data_hold", bus.rsp_rdata, hold_data);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: got rdata 0x%08h want no response", bus.rsp_rdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    check1("sb_write", bus.rsp_write, exp_e.write);
                    check32("sb_rdata", bus.rsp_rdata, exp_e.data);
                end
            end
            hold_pending = bus.rsp_valid && !bus.rsp_ready;
            hold_data    = bus.rsp_rdata;
            if (bus.req_valid && bus.req_ready) begin
                if (|bus.req_wen) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.req_wen[b]) ref_mem[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
                    exp_q.push_back('{1'b1, 32'h0});
                end else begin
                    exp_q.push_back('{1'b0, ref_mem[bus.req_addr]});
                end
            end
        end
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] w, input logic [5:0] a, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_wen   = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    typedef struct {
        logic [3:0]  wen;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        exp_write;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[10];

    int k, first, last, acc, addr_n, lat, ops, cyc;
    logic fired;

    initial begin
        vecs[0] = '{4'hF, 6'd7,  32'hCAFEF00D, 1'b1, 32'h0};
        vecs[1] = '{4'h0, 6'd7,  32'h0,        1'b0, 32'hCAFEF00D};
        vecs[2] = '{4'hF, 6'd9,  32'h11223344, 1'b1, 32'h0};
        vecs[3] = '{4'h2, 6'd9,  32'h0000AB00, 1'b1, 32'h0};
        vecs[4] = '{4'h0, 6'd9,  32'h0,        1'b0, 32'h1122AB44};
        vecs[5] = '{4'h9, 6'd9,  32'hA5A5A5A5, 1'b1, 32'h0};
        vecs[6] = '{4'h0, 6'd9,  32'h0,        1'b0, 32'hA522ABA5};
        vecs[7] = '{4'h1, 6'd63, 32'hFFFFFFFF, 1'b1, 32'h0};
        vecs[8] = '{4'h0, 6'd63, 32'h0,        1'b0, 32'h000000FF};
        vecs[9] = '{4'h0, 6'd0,  32'h0,        1'b0, 32'h0};

        for (int i = 0; i < NDATA; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        drive(1'b0, 4'h0, 6'd0, 32'h0);
        bus.rsp_ready = 1'b1;
        reset = 1'b0;
        repeat (3) next();

        @(negedge clock);
        check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check1("rst_req_ready", bus.req_ready, 1'b0);
        check1("rst_ram_en", ram_en, 1'b0);
        check32("rst_ram_wen", {28'h0, ram_wen}, 32'h0);
        check32("rst_ram_addr", {26'h0, ram_addr}, 32'h0);
        check32("rst_ram_wdata", ram_wdata, 32'h0);
        check32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        next();
        reset = 1'b1;
        @(negedge clock);
        check1("idle_req_ready", bus.req_ready, 1'b1);
        next();

        // Write then read of the same word on consecutive cycles.
        drive(1'b1, 4'hF, 6'd5, 32'hDEADBEEF);
        @(negedge clock);
        check1("t1_ready", bus.req_ready, 1'b1);
        check1("t1_ram_en", ram_en, 1'b1);
        check32("t1_ram_wen", {28'h0, ram_wen}, 32'hF);
        check32("t1_ram_addr", {26'h0, ram_addr}, 32'd5);
        check32("t1_ram_wdata", ram_wdata, 32'hDEADBEEF);
        next();
        drive(1'b1, 4'h0, 6'd5, 32'h0);
        @(negedge clock);
        check1("t1_rsp_early", bus.rsp_valid, 1'b0);
        check32("t1_read_wen", {28'h0, ram_wen}, 32'h0);
        next();
        bus.req_valid = 1'b0;
        @(negedge clock);
        check1("t1_ack_valid", bus.rsp_valid, 1'b1);
        check1("t1_ack_write", bus.rsp_write, 1'b1);
        check32("t1_ack_rdata", bus.rsp_rdata, 32'h0);
        check1("t1_idle_en", ram_en, 1'b0);
        check32("t1_addr_held", {26'h0, ram_addr}, 32'd5);
        next();
        @(negedge clock);
        check1("t1_rd_valid", bus.rsp_valid, 1'b1);
        check1("t1_rd_write", bus.rsp_write, 1'b0);
        check32("t1_rd_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        next();
        next();

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            @(negedge clock);
            check1($sformatf("vec%0d_ready", i), bus.req_ready, 1'b1);
            next();
            bus.req_valid = 1'b0;
            lat = 1;
            @(negedge clock);
            while (!bus.rsp_valid && lat < 10) begin
                next();
                @(negedge clock);
                lat++;
            end
            check32($sformatf("vec%0d_latency", i), lat, 32'd2);
            check1($sformatf("vec%0d_write", i), bus.rsp_write, vecs[i].exp_write);
            check32($sformatf("vec%0d_rdata", i), bus.rsp_rdata, vecs[i].exp_rdata);
            next();
        end

        // Back-to-back reads of a preloaded region.
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'hF, 6'(a), a * 32'h01010101);
            next();
        end
        bus.req_valid = 1'b0;
        repeat (4) next();
        k = 0; first = -1; last = -1;
        for (int c = 0; c < 18; c++) begin
            if (c < 16) drive(1'b1, 4'h0, 6'(c), 32'h0);
            else bus.req_valid = 1'b0;
            @(negedge clock);
            if (c < 16) check1($sformatf("b2b_ready%0d", c), bus.req_ready, 1'b1);
            if (bus.rsp_valid) begin
                check32($sformatf("b2b_data%0d", k), bus.rsp_rdata, k * 32'h01010101);
                if (first < 0) first = c;
                last = c;
                k++;
            end
            next();
        end
        check32("b2b_count", k, 32'd16);
        check32("b2b_first", first, 32'd2);
        check32("b2b_last", last, 32'd17);

        // Response backpressure fills the FIFO.
        bus.rsp_ready = 1'b0;
        acc = 0; addr_n = 3;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 4'h0, 6'(addr_n), 32'h0);
            @(negedge clock);
            if (bus.req_ready) begin acc++; addr_n++; end
            if (c >= 3) check1($sformatf("bp_not_ready%0d", c), bus.req_ready, 1'b0);
            if (c >= 2) begin
                check1($sformatf("bp_head_valid%0d", c), bus.rsp_valid, 1'b1);
                check32($sformatf("bp_head_data%0d", c), bus.rsp_rdata, 32'h03030303);
            end
            next();
        end
        check32("bp_accepted", acc, 32'd3);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (bus.rsp_valid) begin
                check32($sformatf("bp_drain%0d", k), bus.rsp_rdata, (3 + k) * 32'h01010101);
                k++;
            end
            next();
        end
        check32("bp_drained", k, 32'd3);
        @(negedge clock);
        check1("bp_ready_back", bus.req_ready, 1'b1);
        next();

        // Reset with two buffered responses and one inflight request.
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'h0, 6'(10 + c), 32'h0);
            @(negedge clock);
            check1($sformatf("mr_ready%0d", c), bus.req_ready, 1'b1);
            next();
        end
        bus.req_valid = 1'b0;
        @(negedge clock);
        check1("mr_pre_valid", bus.rsp_valid, 1'b1);
        check1("mr_pre_full", bus.req_ready, 1'b0);
        next();
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        check1("mr_in_ready", bus.req_ready, 1'b0);
        next();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check1($sformatf("mr_post_valid%0d", c), bus.rsp_valid, 1'b0);
            check1($sformatf("mr_post_ready%0d", c), bus.req_ready, 1'b1);
            check32($sformatf("mr_post_rdata%0d", c), bus.rsp_rdata, 32'h0);
            next();
        end

        // Random request/response mix checked by the scoreboard.
        ops = 0; cyc = 0;
        while (ops < 1000 && cyc < 20000) begin
            if (!bus.req_valid && ($urandom_range(0, 9) < 7))
                drive(1'b1, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                      6'($urandom_range(0, 15)), $urandom);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clock);
            fired = bus.req_valid && bus.req_ready;
            next();
            if (fired) begin
                ops++;
                bus.req_valid = 1'b0;
            end
            cyc++;
        end
        check32("rand_ops", ops, 32'd1000);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) next();
        repeat (2) next();
        check32("rand_drained", exp_q.size(), 32'd0);
        @(negedge clock);
        check1("final_rsp_valid", bus.rsp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
